// File: rtl/alu_uart_ctrl.sv
// Frame sequencer between a UART byte receiver/transmitter and a combinational ALU.
// Collects operand A, operand B and an op byte, then sends the ALU result back as one byte.
module alu_uart_ctrl #(
  parameter int NB_DATA      = 8,
  parameter int NB_OPERATION = 6,
  parameter int TIMEOUT      = 1000,
  parameter int NB_TIMER     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NB_DATA-1:0]      i_rx_data,
  input  logic                    i_rx_done,
  input  logic [NB_DATA-1:0]      i_alu_result,
  input  logic                    i_tx_done,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic [NB_OPERATION-1:0] o_op,
  output logic [NB_DATA-1:0]      o_tx_data,
  output logic                    o_tx_start,
  output logic                    o_busy,
  output logic                    o_rx_drop,
  output logic                    o_timeout
);

  typedef enum logic [2:0] {
    S_A       = 3'd0,
    S_B       = 3'd1,
    S_OP      = 3'd2,
    S_EXEC    = 3'd3,
    S_TX      = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  localparam bit                  TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [NB_TIMER-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : NB_TIMER'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [NB_DATA-1:0]      data_a_q, data_a_d;
  logic [NB_DATA-1:0]      data_b_q, data_b_d;
  logic [NB_OPERATION-1:0] op_q, op_d;
  logic [NB_DATA-1:0]      tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    rx_drop_q, rx_drop_d;
  logic                    timeout_q, timeout_d;
  logic [NB_TIMER-1:0]     timer_q, timer_d;

  logic in_frame;
  logic busy;
  logic timer_expired;

  assign in_frame = (state_q == S_B) || (state_q == S_OP);
  assign busy     = (state_q == S_EXEC) || (state_q == S_TX) || (state_q == S_WAIT_TX);

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timer_expired = TIMEOUT_EN && in_frame && (timer_q == TIMER_LAST) && !i_rx_done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rx_drop_q  <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rx_drop_q  <= rx_drop_d;
      timeout_q  <= timeout_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:       if (i_rx_done) state_d = S_B;
      S_B: begin
        if (i_rx_done)          state_d = S_OP;
        else if (timer_expired) state_d = S_A;
      end
      S_OP: begin
        if (i_rx_done)          state_d = S_EXEC;
        else if (timer_expired) state_d = S_A;
      end
      S_EXEC:    state_d = S_TX;
      S_TX:      state_d = S_WAIT_TX;
      S_WAIT_TX: if (i_tx_done) state_d = S_A;
      default:   state_d = S_A;
    endcase
  end

  always_comb begin
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rx_drop_d  = 1'b0;
    timeout_d  = timer_expired;
    timer_d    = '0;

    if (i_rx_done) begin
      case (state_q)
        S_A:     data_a_d = i_rx_data;
        S_B:     data_b_d = i_rx_data;
        S_OP:    op_d     = i_rx_data[NB_OPERATION-1:0];
        default: rx_drop_d = 1'b1;
      endcase
    end

    // Operands are stable on the ALU during S_EXEC, so its result is captured there.
    if (state_q == S_EXEC) begin
      tx_data_d  = i_alu_result;
      tx_start_d = 1'b1;
    end

    if (in_frame && (state_d == state_q) && !i_rx_done) timer_d = timer_q + 1'b1;
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy;
  assign o_rx_drop  = rx_drop_q;
  assign o_timeout  = timeout_q;

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
Sequencer between a UART byte receiver/transmitter pair and the combinational ALU. It collects three received bytes (operand A, operand B, operation code) and drives them as registered operands to the ALU. It then captures the ALU result and hands it to the UART transmitter as one byte. It is the operand producer and result consumer at the other end of the ALU's operand/op/result interface.

Parameters:
NB_DATA, 8, width of operands, result and UART data bytes
NB_OPERATION, 6, width of the ALU operation code; taken from the low bits of the op byte (NB_OPERATION <= NB_DATA)
TIMEOUT, 1000, idle clock cycles allowed between bytes of one frame; 0 disables the timeout
NB_TIMER, 16, width of the inter-byte timer (2**NB_TIMER > TIMEOUT)

Ports:
i_clk  input  1  system clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_rx_data  input  NB_DATA  byte from the UART receiver, valid when i_rx_done=1
i_rx_done  input  1  one-cycle pulse, a received byte is valid
i_alu_result  input  NB_DATA  combinational result from the ALU
i_tx_done  input  1  one-cycle pulse, transmitter finished the byte
o_data_a  output  NB_DATA  registered operand A to the ALU
o_data_b  output  NB_DATA  registered operand B to the ALU
o_op  output  NB_OPERATION  registered operation code to the ALU
o_tx_data  output  NB_DATA  result byte to the transmitter, stable from the o_tx_start cycle until i_tx_done
o_tx_start  output  1  one-cycle pulse requesting transmission
o_busy  output  1  high in S_EXEC, S_TX and S_WAIT_TX
o_rx_drop  output  1  one-cycle pulse, a byte arrived while busy and was discarded
o_timeout  output  1  one-cycle pulse, a partial frame was abandoned

Behaviour:
- Reset (async, active-high): state=S_A; o_data_a, o_data_b, o_op, o_tx_data = 0; o_tx_start, o_busy, o_rx_drop, o_timeout = 0; timer=0. Reset mid-frame or mid-transmit discards everything. No tx_start is issued after reset.
- All outputs are registered. Only o_busy may be decoded from the state register.
- States:
  - S_A: on i_rx_done, o_data_a<=i_rx_data, go to S_B.
  - S_B: on i_rx_done, o_data_b<=i_rx_data, go to S_OP.
  - S_OP: on i_rx_done, o_op<=i_rx_data[NB_OPERATION-1:0], go to S_EXEC. Upper op-byte bits are ignored.
  - S_EXEC: exactly 1 cycle; the ALU sees stable operands here. o_tx_data<=i_alu_result, go to S_TX.
  - S_TX: o_tx_start=1 for this single cycle, go to S_WAIT_TX.
  - S_WAIT_TX: on i_tx_done, go to S_A. i_tx_done in any other state is ignored.
- Latency: third byte's i_rx_done at cycle N -> o_tx_start high at cycle N+2, with o_tx_data valid.
- Operand registers hold their value until overwritten by the next frame. They are not cleared on timeout or after transmit.
- Timer:
  - Counts only in S_B and S_OP.
  - Cleared on every accepted byte and on every state change.
  - If TIMEOUT!=0 and the timer reaches TIMEOUT-1 without i_rx_done, the next state is S_A, o_timeout pulses for 1 cycle and the timer clears.
  - If i_rx_done coincides with the expiry cycle, the byte wins: it is accepted and there is no timeout.
- i_rx_done in S_EXEC, S_TX or S_WAIT_TX: the byte is discarded, o_rx_drop pulses for 1 cycle, and the state is unaffected.
- i_rx_done and i_tx_done in the same cycle in S_WAIT_TX: go to S_A, the byte is dropped with an o_rx_drop pulse, and it is not taken as operand A.
- Arithmetic is performed only by the ALU. This block does no width extension; the result is passed through as NB_DATA bits.
- Op codes are not validated. An unknown code is forwarded, and the ALU default result is transmitted.

Test Plan:
- ADD frame: rx 0x05, 0x03, 0x08, with a real ALU instance -> o_op=0x08, o_tx_start 2 cycles after the third rx_done, o_tx_data=0x08. i_tx_done returns to S_A, o_busy falls.
- SUB wrap and op masking: rx 0x03, 0x05, 0xCA (low 6 bits = 0x0A) -> o_op=0x0A, o_tx_data=0xFE.
- Timeout: TIMEOUT=20; rx 0x11 then no byte for 20 cycles -> o_timeout single pulse, state S_A, o_data_a stays 0x11. Next frame 0x01, 0x02, 0x08 -> tx 0x03. Also check that a byte landing exactly on the expiry cycle is accepted with no o_timeout.
- Drop while busy: a full frame, then rx_done pulses in S_EXEC and in S_WAIT_TX -> o_rx_drop pulse each time, transmitted byte unchanged. Simultaneous rx_done + tx_done -> dropped, state S_A.
- Async reset: assert i_reset mid-S_OP and again mid-S_WAIT_TX, not aligned to i_clk -> all outputs 0 immediately, no o_tx_start after release. A following frame 0xF0, 0x0F, 0x0D (OR) -> tx 0xFF.
